// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//
// Contents:
//   state_t    - controller states (IDLE, RUN, DONE), two-bit encoding
//   cnt_width  - width of the iteration counter for a given operand width
package seq_mult_pkg;

  // Controller states. The encoding is fixed because the outputs are decoded
  // directly from the state register.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // The counter has to hold values 0..width. It reaches width on the final
  // RUN edge, just as the controller leaves RUN.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/fa.sv
// Single-bit full adder cell. This is the leaf cell of the ripple-carry adder.
//
// Ports:
//   a, b  - addend bits
//   cin   - carry in
//   sum   - a ^ b ^ cin
//   cout  - carry out
module fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/rca_n.sv
// N-bit ripple-carry adder built as a chain of fa cells.
//
// Parameters:
//   N     - operand width
// Ports:
//   a, b  - N-bit operands
//   cin   - carry into bit 0
//   sum   - N-bit sum
//   cout  - carry out of bit N-1
module rca_n #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_bit
    fa u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (carry[i]),
      .sum (sum[i]),
      .cout(carry[i+1])
    );
  end

  assign cout = carry[N];

endmodule

// File: rtl/seq_mult.sv
// Unsigned sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// The block handles one multiplier bit per clock. It takes exactly WIDTH RUN
// cycles per product and uses valid/ready handshakes on both the input side
// and the output side.
//
// Parameters:
//   WIDTH      - operand width, 2..32
// Ports:
//   clk        - rising-edge clock
//   rst        - asynchronous reset, active-high
//   in_valid   - operands a/b present
//   in_ready   - block can accept operands (IDLE)
//   a          - multiplicand
//   b          - multiplier
//   out_valid  - product p is valid (DONE)
//   out_ready  - consumer accepts p
//   p          - product a*b, held until the next product is loaded
//   busy       - high while iterating (RUN)
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int             CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum_lo;
  logic             sum_hi;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] mplier_next;
  logic             last_iter;

  // Partial product: add the multiplicand only when the current multiplier
  // LSB is set. The carry out becomes bit WIDTH of the sum, so the add can
  // never overflow.
  assign addend = mplier[0] ? mcand : '0;

  rca_n #(
    .N(WIDTH)
  ) u_rca (
    .a   (acc),
    .b   (addend),
    .cin (1'b0),
    .sum (sum_lo),
    .cout(sum_hi)
  );

  // Shift the combined {sum, mplier} right by one bit. The sum LSB moves into
  // the top of mplier, so after WIDTH steps {acc, mplier} holds the product.
  assign acc_next    = {sum_hi, sum_lo[WIDTH-1:1]};
  assign mplier_next = {sum_lo[0], mplier[WIDTH-1:1]};
  assign last_iter   = (cnt == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. The outputs are decoded from the state register only,
  // so in_ready, busy and out_valid have no combinational path from inputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last_iter) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Datapath. Operands are captured only in IDLE. Reset discards any
  // operation in flight, so a partially built product is never published.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      p      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        ST_RUN: begin
          acc    <= acc_next;
          mplier <= mplier_next;
          cnt    <= cnt + CNT_W'(1);
          if (last_iter) begin
            p <= {acc_next, mplier_next};
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult. It drives three instances (WIDTH = 4, 8
// and 16) from a shared clock.
module tb_seq_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  // WIDTH=4 instance
  logic       rst4, in_valid4, in_ready4, out_valid4, out_ready4, busy4;
  logic [3:0] a4, b4;
  logic [7:0] p4;

  // WIDTH=8 instance
  logic        rst8, in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  // WIDTH=16 instance
  logic        rst16, in_valid16, in_ready16, out_valid16, out_ready16, busy16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  seq_mult #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst4), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(out_ready4),
    .p(p4), .busy(busy4)
  );

  seq_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
    .p(p8), .busy(busy8)
  );

  seq_mult #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst16), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .out_valid(out_valid16), .out_ready(out_ready16),
    .p(p16), .busy(busy16)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
    int          stall;
  } vec_t;

  vec_t vecs[8];

  localparam int NRAND = 1000;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One full WIDTH=8 transaction: accept, wait for the product, hold it for
  // 'stall' cycles of back-pressure, then hand it off with an out_ready pulse.
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv,
                               input logic [15:0] pexp, input int stall,
                               input string tag);
    int k;
    @(negedge clk);
    checkOutput({tag, " in_ready idle"}, 64'(in_ready8), 64'd1);
    a8 = av; b8 = bv; in_valid8 = 1'b1; out_ready8 = 1'b0;
    @(negedge clk);
    in_valid8 = 1'b0;
    checkOutput({tag, " busy after accept"}, 64'(busy8), 64'd1);
    k = 0;
    while (!out_valid8 && k < 40) begin
      @(negedge clk);
      k++;
    end
    checkOutput({tag, " latency"}, 64'(k), 64'd8);
    checkOutput({tag, " p"}, 64'(p8), 64'(pexp));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      checkOutput({tag, " hold out_valid"}, 64'(out_valid8), 64'd1);
      checkOutput({tag, " hold in_ready"}, 64'(in_ready8), 64'd0);
      checkOutput({tag, " hold p"}, 64'(p8), 64'(pexp));
    end
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
    checkOutput({tag, " out_valid dropped"}, 64'(out_valid8), 64'd0);
    checkOutput({tag, " in_ready back"}, 64'(in_ready8), 64'd1);
    checkOutput({tag, " p kept"}, 64'(p8), 64'(pexp));
  endtask

  initial begin
    int k;
    int first_k, second_k;
    logic [15:0] first_p, second_p;
    logic saw_valid;
    int accepts, products, cycles;
    logic pv_iv, pv_ir, pv_ov, pv_or;
    logic [31:0] pv_p;
    logic [15:0] pv_a, pv_b;
    logic [31:0] expq[$];
    logic [31:0] expv;

    vecs[0] = '{a: 8'd13,  b: 8'd11,  p: 16'd143,   stall: 20};
    vecs[1] = '{a: 8'd100, b: 8'd3,   p: 16'd300,   stall: 0};
    vecs[2] = '{a: 8'd0,   b: 8'd200, p: 16'd0,     stall: 1};
    vecs[3] = '{a: 8'd255, b: 8'd255, p: 16'd65025, stall: 2};
    vecs[4] = '{a: 8'd7,   b: 8'd9,   p: 16'd63,    stall: 0};
    vecs[5] = '{a: 8'd1,   b: 8'd1,   p: 16'd1,     stall: 0};
    vecs[6] = '{a: 8'd255, b: 8'd1,   p: 16'd255,   stall: 3};
    vecs[7] = '{a: 8'd128, b: 8'd2,   p: 16'd256,   stall: 0};

    rst4 = 1'b1; rst8 = 1'b1; rst16 = 1'b1;
    in_valid4 = 0; in_valid8 = 0; in_valid16 = 0;
    out_ready4 = 0; out_ready8 = 0; out_ready16 = 0;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0; a16 = '0; b16 = '0;

    #1;
    checkOutput("reset in_ready", 64'(in_ready8), 64'd1);
    checkOutput("reset out_valid", 64'(out_valid8), 64'd0);
    checkOutput("reset busy", 64'(busy8), 64'd0);
    checkOutput("reset p", 64'(p8), 64'd0);
    checkOutput("reset p16", 64'(p16), 64'd0);
    @(negedge clk);
    rst4 = 1'b0; rst8 = 1'b0; rst16 = 1'b0;

    // WIDTH=4: 15*15 with the consumer always ready
    @(negedge clk);
    a4 = 4'd15; b4 = 4'd15; in_valid4 = 1'b1; out_ready4 = 1'b1;
    @(negedge clk);
    in_valid4 = 1'b0;
    k = 0;
    while (!out_valid4 && k < 20) begin
      @(negedge clk);
      k++;
    end
    checkOutput("w4 latency", 64'(k), 64'd4);
    checkOutput("w4 p", 64'(p4), 64'd225);
    checkOutput("w4 in_ready during out_valid", 64'(in_ready4), 64'd0);
    @(negedge clk);
    checkOutput("w4 out_valid dropped", 64'(out_valid4), 64'd0);
    checkOutput("w4 in_ready back", 64'(in_ready4), 64'd1);
    out_ready4 = 1'b0;

    // WIDTH=8 directed table
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].stall,
                    $sformatf("vec%0d", i));
    end

    // Back-to-back accepts with in_valid held high. The operands change
    // mid-flight and must be ignored until the next IDLE edge.
    @(negedge clk);
    a8 = 8'd0; b8 = 8'd200; in_valid8 = 1'b1; out_ready8 = 1'b1;
    first_k = -1; second_k = -1; first_p = '0; second_p = '0;
    for (k = 0; k <= 19; k++) begin
      @(negedge clk);
      if (k == 0) begin
        a8 = 8'd255; b8 = 8'd255;
      end
      if (out_valid8) begin
        if (first_k < 0) begin
          first_k = k; first_p = p8;
        end else if (second_k < 0) begin
          second_k = k; second_p = p8;
        end
      end
      if (k == 18) in_valid8 = 1'b0;
    end
    checkOutput("b2b first edge", 64'(first_k), 64'd8);
    checkOutput("b2b first p", 64'(first_p), 64'd0);
    checkOutput("b2b second edge", 64'(second_k), 64'd18);
    checkOutput("b2b second p", 64'(second_p), 64'd65025);
    checkOutput("b2b idle after", 64'(in_ready8), 64'd1);
    out_ready8 = 1'b0;

    // in_valid toggled during RUN with other operands must be ignored
    @(negedge clk);
    a8 = 8'd100; b8 = 8'd3; in_valid8 = 1'b1;
    @(negedge clk);
    saw_valid = 1'b0;
    for (k = 1; k <= 8; k++) begin
      in_valid8 = k[0];
      a8 = 8'(50 + k); b8 = 8'(k + 20);
      @(negedge clk);
      if (k < 8 && out_valid8) saw_valid = 1'b1;
    end
    in_valid8 = 1'b0;
    checkOutput("toggle early out_valid", 64'(saw_valid), 64'd0);
    checkOutput("toggle out_valid", 64'(out_valid8), 64'd1);
    checkOutput("toggle p", 64'(p8), 64'd300);
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
    checkOutput("toggle back to idle", 64'(in_ready8), 64'd1);

    // Asynchronous reset mid-RUN, asserted between clock edges
    a8 = 8'd200; b8 = 8'd200; in_valid8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("pre-reset busy", 64'(busy8), 64'd1);
    #2;
    rst8 = 1'b1;
    #1;
    checkOutput("async rst in_ready", 64'(in_ready8), 64'd1);
    checkOutput("async rst busy", 64'(busy8), 64'd0);
    checkOutput("async rst out_valid", 64'(out_valid8), 64'd0);
    checkOutput("async rst p", 64'(p8), 64'd0);
    @(negedge clk);
    rst8 = 1'b0;
    saw_valid = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid8) saw_valid = 1'b1;
    end
    checkOutput("aborted op out_valid", 64'(saw_valid), 64'd0);
    applyStimulus(8'd7, 8'd9, 16'd63, 0, "post-reset");

    // WIDTH=16 random operands with random consumer stalls
    accepts = 0; products = 0; cycles = 0;
    pv_iv = 0; pv_ir = 0; pv_ov = 0; pv_or = 0;
    pv_p = '0; pv_a = '0; pv_b = '0;
    while (products < NRAND && cycles < 40000) begin
      @(negedge clk);
      cycles++;
      if (pv_iv && pv_ir) begin
        expq.push_back(32'(pv_a) * 32'(pv_b));
        accepts++;
      end
      if (pv_ov && pv_or) begin
        if (expq.size() == 0) begin
          checkOutput("rand spurious product", 64'd1, 64'd0);
        end else begin
          expv = expq.pop_front();
          checkOutput($sformatf("rand p #%0d", products), 64'(pv_p), 64'(expv));
        end
        products++;
      end
      in_valid16  = (accepts < NRAND) && ($urandom_range(0, 3) != 0);
      a16         = 16'($urandom);
      b16         = 16'($urandom);
      out_ready16 = ($urandom_range(0, 2) != 0);
      pv_iv = in_valid16; pv_ir = in_ready16;
      pv_ov = out_valid16; pv_or = out_ready16;
      pv_p  = p16; pv_a = a16; pv_b = b16;
    end
    in_valid16 = 1'b0;
    out_ready16 = 1'b0;
    checkOutput("rand product count", 64'(products), 64'(NRAND));
    checkOutput("rand accepts vs products", 64'(accepts), 64'(products));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
